// File: rtl/axi_xbar_decode_pkg.sv
// ---------------------------------------------------------------------------
// axi_xbar_pkg
// Shared types and constants for the single-master, two-target AXI4 address
// decoder (axi_xbar_decode) and its address-decode sub-module.
//
// Contents:
//   rdState_e  : read FSM states  (R_IDLE, R_EXT, R_CLT, R_ERR)
//   wrState_e  : write FSM states (W_IDLE, W_EXT, W_ERRD, W_ERRB)
//   tgtSel_e   : decode result    (TGT_EXT, TGT_CLT, TGT_ERR)
//   RESP_*     : AXI response codes used by the locally terminated paths
//   XBAR_*     : default memory map (CLINT window, start of EXT space)
//   decodeAddr : address -> target helper shared by both decode instances
// ---------------------------------------------------------------------------
package axi_xbar_pkg;

   localparam logic [31:0] XBAR_CLINT_BASE = 32'h0200_0000;
   localparam logic [31:0] XBAR_CLINT_MASK = 32'hFFFF_0000;
   localparam logic [31:0] XBAR_EXT_BASE   = 32'h2000_0000;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_EXT  = 2'd1,
      R_CLT  = 2'd2,
      R_ERR  = 2'd3
   } rdState_e;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_EXT  = 2'd1,
      W_ERRD = 2'd2,
      W_ERRB = 2'd3
   } wrState_e;

   typedef enum logic [1:0] {
      TGT_EXT = 2'd0,
      TGT_CLT = 2'd1,
      TGT_ERR = 2'd2
   } tgtSel_e;

   // CLINT takes priority over EXT so a CLINT window placed above the EXT
   // base would still route to the CLINT.
   function automatic tgtSel_e decodeAddr(input logic [31:0] addr,
                                          input logic [31:0] clintBase,
                                          input logic [31:0] clintMask,
                                          input logic [31:0] extBase);
      tgtSel_e tgt;
      if ((addr & clintMask) == clintBase) begin
         tgt = TGT_CLT;
      end else if (addr >= extBase) begin
         tgt = TGT_EXT;
      end else begin
         tgt = TGT_ERR;
      end
      return tgt;
   endfunction

endpackage

// File: rtl/axi_xbar_decode_if.sv
// ---------------------------------------------------------------------------
// axi_xbar_decode_if
// AXI4 bundle (AR, R, AW, W, B) with 32-bit address/data.
//
// Parameters: ID_W - AXI ID width.
// Modports:
//   master : drives AR/AW/W payload+valid, R/B ready (bus initiator side)
//   slave  : drives AR/AW/W ready, R/B payload+valid (bus target side)
// ---------------------------------------------------------------------------
interface axi_xbar_decode_if #(
   parameter int ID_W = 4
);

   logic            arvalid;
   logic            arready;
   logic [31:0]     araddr;
   logic [ID_W-1:0] arid;
   logic [7:0]      arlen;
   logic [2:0]      arsize;
   logic [1:0]      arburst;

   logic            rvalid;
   logic            rready;
   logic [31:0]     rdata;
   logic [1:0]      rresp;
   logic [ID_W-1:0] rid;
   logic            rlast;

   logic            awvalid;
   logic            awready;
   logic [31:0]     awaddr;
   logic [ID_W-1:0] awid;
   logic [7:0]      awlen;
   logic [2:0]      awsize;
   logic [1:0]      awburst;

   logic            wvalid;
   logic            wready;
   logic [31:0]     wdata;
   logic [3:0]      wstrb;
   logic            wlast;

   logic            bvalid;
   logic            bready;
   logic [1:0]      bresp;
   logic [ID_W-1:0] bid;

   modport master (
      output arvalid, araddr, arid, arlen, arsize, arburst,
      input  arready,
      input  rvalid, rdata, rresp, rid, rlast,
      output rready,
      output awvalid, awaddr, awid, awlen, awsize, awburst,
      input  awready,
      output wvalid, wdata, wstrb, wlast,
      input  wready,
      input  bvalid, bresp, bid,
      output bready
   );

   modport slave (
      input  arvalid, araddr, arid, arlen, arsize, arburst,
      output arready,
      output rvalid, rdata, rresp, rid, rlast,
      input  rready,
      input  awvalid, awaddr, awid, awlen, awsize, awburst,
      output awready,
      input  wvalid, wdata, wstrb, wlast,
      output wready,
      output bvalid, bresp, bid,
      input  bready
   );

endinterface

// File: rtl/axi_xbar_decode_addr.sv
// ---------------------------------------------------------------------------
// axi_addr_decode
// Purely combinational address-to-target decode. One instance serves the AR
// path and one the AW path of axi_xbar_decode.
//
// Ports:
//   addr_i : 32-bit transaction address
//   tgt_o  : TGT_CLT on a CLINT window hit, else TGT_EXT at/above EXT_BASE,
//            else TGT_ERR (unmapped)
// ---------------------------------------------------------------------------
module axi_addr_decode
   import axi_xbar_pkg::*;
#(
   parameter logic [31:0] CLINT_BASE = XBAR_CLINT_BASE,
   parameter logic [31:0] CLINT_MASK = XBAR_CLINT_MASK,
   parameter logic [31:0] EXT_BASE   = XBAR_EXT_BASE
) (
   input  logic [31:0] addr_i,
   output tgtSel_e     tgt_o
);

   assign tgt_o = decodeAddr(addr_i, CLINT_BASE, CLINT_MASK, EXT_BASE);

endmodule

// File: rtl/axi_xbar_decode.sv
// ---------------------------------------------------------------------------
// axi_xbar_decode
// Single-master AXI4 decoder sitting below the IFU/LSU arbiter. Reads go to
// the external SoC bus (EXT) or the read-only CLINT; writes go to EXT only.
// Unmapped accesses and CLINT writes are answered locally with error
// responses. Read and write paths are independent, one transaction each.
//
// Ports:
//   i_clock    : clock
//   i_reset    : synchronous, active-high reset
//   s          : upstream AXI slave port (from the arbiter)
//   e          : EXT AXI master port (all five channels)
//   c          : CLINT AXI master port (only AR/R are used; AW/W/B tied off)
//   o_skip_ref : only when YSYX_XBAR_SKIP_EN is defined; one-cycle pulse on
//                the final R beat of a CLINT/error read and on the B
//                handshake of a locally terminated write
//
// Optional feature macro: YSYX_XBAR_SKIP_EN
// ---------------------------------------------------------------------------
module axi_xbar_decode
   import axi_xbar_pkg::*;
#(
   parameter logic [31:0] CLINT_BASE = XBAR_CLINT_BASE,
   parameter logic [31:0] CLINT_MASK = XBAR_CLINT_MASK,
   parameter logic [31:0] EXT_BASE   = XBAR_EXT_BASE,
   parameter int          ID_W       = 4
) (
   input  logic               i_clock,
   input  logic               i_reset,
   axi_xbar_decode_if.slave   s,
   axi_xbar_decode_if.master  e,
   axi_xbar_decode_if.master  c
`ifdef YSYX_XBAR_SKIP_EN
   ,
   output logic               o_skip_ref
`endif
);

   tgtSel_e         arTgt;
   tgtSel_e         awTgt;

   rdState_e        rdState_q, rdState_d;
   logic            arDone_q, arDone_d;
   logic [ID_W-1:0] arId_q, arId_d;
   logic [7:0]      arLen_q, arLen_d;
   logic [7:0]      beatCnt_q, beatCnt_d;

   wrState_e        wrState_q, wrState_d;
   logic            awDone_q, awDone_d;
   logic            wDone_q, wDone_d;
   logic [ID_W-1:0] awId_q, awId_d;
   logic [1:0]      wResp_q, wResp_d;

   logic            arHs;
   logic            rHs;
   logic            errLast;
   logic            awHs;
   logic            wLastHs;
   logic            bHs;
   logic            unusedClintWr;

   axi_addr_decode #(
      .CLINT_BASE (CLINT_BASE),
      .CLINT_MASK (CLINT_MASK),
      .EXT_BASE   (EXT_BASE)
   ) uArDecode (
      .addr_i (s.araddr),
      .tgt_o  (arTgt)
   );

   axi_addr_decode #(
      .CLINT_BASE (CLINT_BASE),
      .CLINT_MASK (CLINT_MASK),
      .EXT_BASE   (EXT_BASE)
   ) uAwDecode (
      .addr_i (s.awaddr),
      .tgt_o  (awTgt)
   );

   assign arHs    = s.arvalid && s.arready;
   assign rHs     = s.rvalid && s.rready;
   assign errLast = (beatCnt_q == arLen_q);
   assign awHs    = s.awvalid && s.awready;
   assign wLastHs = s.wvalid && s.wready && s.wlast;
   assign bHs     = s.bvalid && s.bready;

   // The CLINT is read-only: its write channels are permanently idle.
   assign c.awvalid = 1'b0;
   assign c.awaddr  = '0;
   assign c.awid    = '0;
   assign c.awlen   = '0;
   assign c.awsize  = '0;
   assign c.awburst = '0;
   assign c.wvalid  = 1'b0;
   assign c.wdata   = '0;
   assign c.wstrb   = '0;
   assign c.wlast   = 1'b0;
   assign c.bready  = 1'b0;
   assign unusedClintWr = ^{c.awready, c.wready, c.bvalid, c.bresp, c.bid};

   // Read FSM state register. A reset aborts any in-flight read outright.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         rdState_q <= R_IDLE;
         arDone_q  <= 1'b0;
         arId_q    <= '0;
         arLen_q   <= '0;
         beatCnt_q <= '0;
      end else begin
         rdState_q <= rdState_d;
         arDone_q  <= arDone_d;
         arId_q    <= arId_d;
         arLen_q   <= arLen_d;
         beatCnt_q <= beatCnt_d;
      end
   end

   // Read next-state. IDLE only samples and decodes the address; routing
   // starts the following cycle. arDone marks that the AR handshake already
   // happened so a new upstream AR is not forwarded mid-burst.
   always_comb begin
      rdState_d = rdState_q;
      arDone_d  = arDone_q;
      arId_d    = arId_q;
      arLen_d   = arLen_q;
      beatCnt_d = beatCnt_q;
      case (rdState_q)
         R_IDLE: begin
            if (s.arvalid) begin
               arId_d    = s.arid;
               arLen_d   = s.arlen;
               arDone_d  = 1'b0;
               beatCnt_d = '0;
               case (arTgt)
                  TGT_EXT: rdState_d = R_EXT;
                  TGT_CLT: rdState_d = R_CLT;
                  default: rdState_d = R_ERR;
               endcase
            end
         end
         R_EXT, R_CLT: begin
            if (arHs) arDone_d = 1'b1;
            if (rHs && s.rlast) rdState_d = R_IDLE;
         end
         R_ERR: begin
            if (arHs) arDone_d = 1'b1;
            if (rHs) begin
               if (errLast) rdState_d = R_IDLE;
               else         beatCnt_d = beatCnt_q + 8'd1;
            end
         end
         default: rdState_d = R_IDLE;
      endcase
   end

   // Read channel routing. Only the selected port sees traffic; everything
   // else, and every output while reset is held, stays at zero. The error
   // path accepts AR for one cycle and then generates DECERR beats itself.
   always_comb begin
      s.arready = 1'b0;
      s.rvalid  = 1'b0;
      s.rdata   = '0;
      s.rresp   = '0;
      s.rid     = '0;
      s.rlast   = 1'b0;
      e.arvalid = 1'b0;
      e.araddr  = '0;
      e.arid    = '0;
      e.arlen   = '0;
      e.arsize  = '0;
      e.arburst = '0;
      e.rready  = 1'b0;
      c.arvalid = 1'b0;
      c.araddr  = '0;
      c.arid    = '0;
      c.arlen   = '0;
      c.arsize  = '0;
      c.arburst = '0;
      c.rready  = 1'b0;
      if (!i_reset) begin
         case (rdState_q)
            R_EXT: begin
               e.arvalid = s.arvalid && !arDone_q;
               e.araddr  = s.araddr;
               e.arid    = s.arid;
               e.arlen   = s.arlen;
               e.arsize  = s.arsize;
               e.arburst = s.arburst;
               s.arready = e.arready && !arDone_q;
               s.rvalid  = e.rvalid;
               s.rdata   = e.rdata;
               s.rresp   = e.rresp;
               s.rid     = e.rid;
               s.rlast   = e.rlast;
               e.rready  = s.rready;
            end
            R_CLT: begin
               c.arvalid = s.arvalid && !arDone_q;
               c.araddr  = s.araddr;
               c.arid    = s.arid;
               c.arlen   = s.arlen;
               c.arsize  = s.arsize;
               c.arburst = s.arburst;
               s.arready = c.arready && !arDone_q;
               s.rvalid  = c.rvalid;
               s.rdata   = c.rdata;
               s.rresp   = c.rresp;
               s.rid     = c.rid;
               s.rlast   = c.rlast;
               c.rready  = s.rready;
            end
            R_ERR: begin
               s.arready = !arDone_q;
               s.rvalid  = arDone_q;
               s.rresp   = arDone_q ? RESP_DECERR : RESP_OKAY;
               s.rid     = arDone_q ? arId_q : '0;
               s.rlast   = arDone_q && errLast;
            end
            default: ;
         endcase
      end
   end

   // Write FSM state register. A reset aborts any in-flight write outright.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         wrState_q <= W_IDLE;
         awDone_q  <= 1'b0;
         wDone_q   <= 1'b0;
         awId_q    <= '0;
         wResp_q   <= '0;
      end else begin
         wrState_q <= wrState_d;
         awDone_q  <= awDone_d;
         wDone_q   <= wDone_d;
         awId_q    <= awId_d;
         wResp_q   <= wResp_d;
      end
   end

   // Write next-state. CLINT writes get SLVERR and unmapped writes DECERR;
   // both drain their W data before the locally generated B response.
   always_comb begin
      wrState_d = wrState_q;
      awDone_d  = awDone_q;
      wDone_d   = wDone_q;
      awId_d    = awId_q;
      wResp_d   = wResp_q;
      case (wrState_q)
         W_IDLE: begin
            if (s.awvalid) begin
               awId_d   = s.awid;
               awDone_d = 1'b0;
               wDone_d  = 1'b0;
               case (awTgt)
                  TGT_EXT: begin
                     wrState_d = W_EXT;
                     wResp_d   = RESP_OKAY;
                  end
                  TGT_CLT: begin
                     wrState_d = W_ERRD;
                     wResp_d   = RESP_SLVERR;
                  end
                  default: begin
                     wrState_d = W_ERRD;
                     wResp_d   = RESP_DECERR;
                  end
               endcase
            end
         end
         W_EXT: begin
            if (awHs)    awDone_d  = 1'b1;
            if (wLastHs) wDone_d   = 1'b1;
            if (bHs)     wrState_d = W_IDLE;
         end
         W_ERRD: begin
            if (awHs)    awDone_d  = 1'b1;
            if (wLastHs) wrState_d = W_ERRB;
         end
         W_ERRB: begin
            if (bHs) wrState_d = W_IDLE;
         end
         default: wrState_d = W_IDLE;
      endcase
   end

   // Write channel routing. EXT writes pass AW, W and B straight through;
   // wDone stops W forwarding after the last beat so data for a following
   // write cannot leak into the current one. Error writes accept AW, then
   // sink W, then return B from the latched response and ID.
   always_comb begin
      s.awready = 1'b0;
      s.wready  = 1'b0;
      s.bvalid  = 1'b0;
      s.bresp   = '0;
      s.bid     = '0;
      e.awvalid = 1'b0;
      e.awaddr  = '0;
      e.awid    = '0;
      e.awlen   = '0;
      e.awsize  = '0;
      e.awburst = '0;
      e.wvalid  = 1'b0;
      e.wdata   = '0;
      e.wstrb   = '0;
      e.wlast   = 1'b0;
      e.bready  = 1'b0;
      if (!i_reset) begin
         case (wrState_q)
            W_EXT: begin
               e.awvalid = s.awvalid && !awDone_q;
               e.awaddr  = s.awaddr;
               e.awid    = s.awid;
               e.awlen   = s.awlen;
               e.awsize  = s.awsize;
               e.awburst = s.awburst;
               s.awready = e.awready && !awDone_q;
               e.wvalid  = s.wvalid && !wDone_q;
               e.wdata   = s.wdata;
               e.wstrb   = s.wstrb;
               e.wlast   = s.wlast;
               s.wready  = e.wready && !wDone_q;
               s.bvalid  = e.bvalid;
               s.bresp   = e.bresp;
               s.bid     = e.bid;
               e.bready  = s.bready;
            end
            W_ERRD: begin
               s.awready = !awDone_q;
               s.wready  = awDone_q;
            end
            W_ERRB: begin
               s.bvalid = 1'b1;
               s.bresp  = wResp_q;
               s.bid    = awId_q;
            end
            default: ;
         endcase
      end
   end

`ifdef YSYX_XBAR_SKIP_EN
   // Flags accesses the reference model cannot reproduce: CLINT reads and
   // anything the decoder answered on its own.
   assign o_skip_ref = !i_reset &&
                       ((((rdState_q == R_CLT) || (rdState_q == R_ERR)) && rHs && s.rlast) ||
                        ((wrState_q == W_ERRB) && s.bready));
`endif

endmodule

// File: tb/tb_axi_xbar_decode.sv
// ---------------------------------------------------------------------------
// tb_axi_xbar_decode
// Directed bench for axi_xbar_decode: drives the upstream port, models the
// EXT bus and CLINT as simple always-ready targets, and checks read beats,
// write responses, routing, boundary decodes and mid-burst reset.
// Honours YSYX_XBAR_SKIP_EN when defined.
// ---------------------------------------------------------------------------
module tb_axi_xbar_decode;
   import axi_xbar_pkg::*;

   logic clock;
   logic reset;
   int   assertCount = 0;
   int   failCount   = 0;

   axi_xbar_decode_if #(.ID_W(4)) sBus ();
   axi_xbar_decode_if #(.ID_W(4)) eBus ();
   axi_xbar_decode_if #(.ID_W(4)) cBus ();

`ifdef YSYX_XBAR_SKIP_EN
   logic skipRef;
   int   skipCount;
`endif

   axi_xbar_decode dut (
      .i_clock    (clock),
      .i_reset    (reset),
      .s          (sBus),
      .e          (eBus),
      .c          (cBus)
`ifdef YSYX_XBAR_SKIP_EN
      ,
      .o_skip_ref (skipRef)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation still running, required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point for the whole bench
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Upstream-side monitor, sampled on the falling edge
   logic [31:0] beatData[$];
   logic [1:0]  beatResp[$];
   logic [3:0]  beatId[$];
   logic        beatLast[$];
   logic        cArvSeen;
   logic        eArvSeen;
   logic        eAwvSeen;
   logic [31:0] cAraddrSeen;

   always @(negedge clock) begin
      if (sBus.rvalid && sBus.rready) begin
         beatData.push_back(sBus.rdata);
         beatResp.push_back(sBus.rresp);
         beatId.push_back(sBus.rid);
         beatLast.push_back(sBus.rlast);
      end
      if (cBus.arvalid) begin
         cArvSeen    <= 1'b1;
         cAraddrSeen <= cBus.araddr;
      end
      if (eBus.arvalid) eArvSeen <= 1'b1;
      if (eBus.awvalid) eAwvSeen <= 1'b1;
`ifdef YSYX_XBAR_SKIP_EN
      if (skipRef) skipCount <= skipCount + 1;
`endif
   end

   task automatic clearMonitors();
      beatData.delete();
      beatResp.delete();
      beatId.delete();
      beatLast.delete();
      cArvSeen    = 1'b0;
      eArvSeen    = 1'b0;
      eAwvSeen    = 1'b0;
      cAraddrSeen = '0;
`ifdef YSYX_XBAR_SKIP_EN
      skipCount = 0;
`endif
   endtask

   // EXT target: always ready; read data is 0xE000_0000 + beat index
   initial begin
      logic       rstS, arHs, rHs, awHs, wLastHs, bHs;
      logic [7:0] capLen;
      logic [3:0] capArId, capAwId, rId, bIdQ;
      int         rCnt, rLen;
      logic       awSeen, wSeen;
      rCnt = 0; rLen = 0; rId = '0; bIdQ = '0; awSeen = 1'b0; wSeen = 1'b0;
      eBus.arready = 1'b1; eBus.rvalid = 1'b0; eBus.rdata = '0; eBus.rresp = '0;
      eBus.rid = '0; eBus.rlast = 1'b0; eBus.awready = 1'b1; eBus.wready = 1'b1;
      eBus.bvalid = 1'b0; eBus.bresp = '0; eBus.bid = '0;
      forever begin
         @(negedge clock);
         rstS    = reset;
         arHs    = eBus.arvalid && eBus.arready;
         capLen  = eBus.arlen;
         capArId = eBus.arid;
         rHs     = eBus.rvalid && eBus.rready;
         awHs    = eBus.awvalid && eBus.awready;
         capAwId = eBus.awid;
         wLastHs = eBus.wvalid && eBus.wready && eBus.wlast;
         bHs     = eBus.bvalid && eBus.bready;
         @(posedge clock);
         #1;
         if (rstS) begin
            eBus.rvalid = 1'b0; eBus.bvalid = 1'b0; awSeen = 1'b0; wSeen = 1'b0;
            rCnt = 0; rLen = 0;
         end else begin
            if (rHs) begin
               if (rCnt == rLen) eBus.rvalid = 1'b0;
               else              rCnt++;
            end
            if (arHs) begin
               rLen = int'(capLen); rId = capArId; rCnt = 0; eBus.rvalid = 1'b1;
            end
            eBus.rdata = 32'hE000_0000 + 32'(rCnt);
            eBus.rlast = (rCnt == rLen);
            eBus.rid   = rId;
            eBus.rresp = RESP_OKAY;
            if (bHs) begin
               eBus.bvalid = 1'b0; awSeen = 1'b0; wSeen = 1'b0;
            end
            if (awHs) begin
               awSeen = 1'b1; bIdQ = capAwId;
            end
            if (wLastHs) wSeen = 1'b1;
            if (awSeen && wSeen && !eBus.bvalid) begin
               eBus.bvalid = 1'b1; eBus.bid = bIdQ; eBus.bresp = RESP_OKAY;
            end
         end
      end
   end

   // CLINT target: always ready, single beat of 0x1234
   initial begin
      logic       rstS, arHs, rHs;
      logic [3:0] capId;
      cBus.arready = 1'b1; cBus.rvalid = 1'b0; cBus.rdata = '0; cBus.rresp = '0;
      cBus.rid = '0; cBus.rlast = 1'b0; cBus.awready = 1'b0; cBus.wready = 1'b0;
      cBus.bvalid = 1'b0; cBus.bresp = '0; cBus.bid = '0;
      forever begin
         @(negedge clock);
         rstS  = reset;
         arHs  = cBus.arvalid && cBus.arready;
         rHs   = cBus.rvalid && cBus.rready;
         capId = cBus.arid;
         @(posedge clock);
         #1;
         if (rstS) begin
            cBus.rvalid = 1'b0;
         end else begin
            if (rHs) cBus.rvalid = 1'b0;
            if (arHs) begin
               cBus.rvalid = 1'b1; cBus.rdata = 32'h0000_1234; cBus.rid = capId;
               cBus.rlast = 1'b1; cBus.rresp = RESP_OKAY;
            end
         end
      end
   end

   // Issue one read and sink its beats; optionally toggle rready each cycle
   task automatic applyStimulusRead(input logic [31:0] addr, input logic [7:0] len,
                                    input logic [3:0] id, input bit toggle,
                                    input int maxCycles);
      int cyc = 0;
      bit arDoneL = 1'b0;
      bit done = 1'b0;
      @(posedge clock);
      #1;
      sBus.araddr = addr; sBus.arlen = len; sBus.arid = id;
      sBus.arsize = 3'd2; sBus.arburst = 2'b01; sBus.arvalid = 1'b1;
      sBus.rready = 1'b1;
      while (!done && cyc < maxCycles) begin
         @(negedge clock);
         if (sBus.arvalid && sBus.arready) arDoneL = 1'b1;
         if (sBus.rvalid && sBus.rready && sBus.rlast) done = 1'b1;
         @(posedge clock);
         #1;
         if (arDoneL) sBus.arvalid = 1'b0;
         sBus.rready = toggle ? ~sBus.rready : 1'b1;
         cyc++;
      end
      sBus.arvalid = 1'b0;
      sBus.rready  = 1'b0;
      checkOutput("rdDone", 64'(done), 64'd1);
   endtask

   // Issue one write of nBeats data beats and wait for B
   task automatic applyStimulusWrite(input logic [31:0] addr, input int nBeats,
                                     input logic [3:0] id, input int maxCycles,
                                     output int accepted, output logic [1:0] resp,
                                     output logic [3:0] bidOut);
      int beat = 0;
      int cyc = 0;
      bit awDoneL = 1'b0;
      bit wHs;
      bit done = 1'b0;
      accepted = 0; resp = 2'b01; bidOut = '0;
      @(posedge clock);
      #1;
      sBus.awaddr = addr; sBus.awid = id; sBus.awlen = 8'(nBeats - 1);
      sBus.awsize = 3'd2; sBus.awburst = 2'b01; sBus.awvalid = 1'b1;
      sBus.wvalid = 1'b1; sBus.wdata = 32'hD000_0000; sBus.wstrb = 4'hF;
      sBus.wlast = (nBeats == 1); sBus.bready = 1'b1;
      while (!done && cyc < maxCycles) begin
         @(negedge clock);
         if (sBus.awvalid && sBus.awready) awDoneL = 1'b1;
         wHs = sBus.wvalid && sBus.wready;
         if (wHs) accepted++;
         if (sBus.bvalid && sBus.bready) begin
            done = 1'b1; resp = sBus.bresp; bidOut = sBus.bid;
         end
         @(posedge clock);
         #1;
         if (awDoneL) sBus.awvalid = 1'b0;
         if (wHs) begin
            if (sBus.wlast) begin
               sBus.wvalid = 1'b0; sBus.wlast = 1'b0;
            end else begin
               beat++;
               sBus.wdata = 32'hD000_0000 + 32'(beat);
               sBus.wlast = (beat == nBeats - 1);
            end
         end
         cyc++;
      end
      sBus.awvalid = 1'b0; sBus.wvalid = 1'b0; sBus.bready = 1'b0;
      checkOutput("wrDone", 64'(done), 64'd1);
   endtask

   // Compare collected read beats; mode 0 = error data, 1 = EXT, 2 = CLINT
   task automatic verifyBeats(input string tag, input int expN, input logic [1:0] expResp,
                              input logic [3:0] expId, input int mode);
      int badData = 0, badResp = 0, badId = 0, badLast = 0;
      logic [31:0] expData;
      checkOutput({tag, "Count"}, 64'(beatData.size()), 64'(expN));
      for (int i = 0; i < beatData.size(); i++) begin
         case (mode)
            1:       expData = 32'hE000_0000 + 32'(i);
            2:       expData = 32'h0000_1234;
            default: expData = 32'h0;
         endcase
         if (beatData[i] !== expData) badData++;
         if (beatResp[i] !== expResp) badResp++;
         if (beatId[i] !== expId) badId++;
         if (beatLast[i] !== (i == expN - 1)) badLast++;
      end
      checkOutput({tag, "Data"}, 64'(badData), 64'd0);
      checkOutput({tag, "Resp"}, 64'(badResp), 64'd0);
      checkOutput({tag, "Id"}, 64'(badId), 64'd0);
      checkOutput({tag, "Last"}, 64'(badLast), 64'd0);
   endtask

   function automatic logic [63:0] allHandshakes();
      return 64'({sBus.arready, sBus.rvalid, sBus.awready, sBus.wready, sBus.bvalid,
                  eBus.arvalid, eBus.rready, eBus.awvalid, eBus.wvalid, eBus.bready,
                  cBus.arvalid, cBus.rready});
   endfunction

   int         wAcc;
   logic [1:0] wResp;
   logic [3:0] wBid;
   int         midBeats;
   int         midCyc;
   bit         midArDone;

   initial begin
      reset = 1'b1;
      sBus.arvalid = 1'b0; sBus.araddr = '0; sBus.arid = '0; sBus.arlen = '0;
      sBus.arsize = '0; sBus.arburst = '0; sBus.rready = 1'b0;
      sBus.awvalid = 1'b0; sBus.awaddr = '0; sBus.awid = '0; sBus.awlen = '0;
      sBus.awsize = '0; sBus.awburst = '0; sBus.wvalid = 1'b0; sBus.wdata = '0;
      sBus.wstrb = '0; sBus.wlast = 1'b0; sBus.bready = 1'b0;
      clearMonitors();
      repeat (3) @(posedge clock);
      @(negedge clock);
      checkOutput("rstHandshakes", allHandshakes(), 64'd0);
      checkOutput("rstPayload", 64'({sBus.rdata, sBus.rid, sBus.rresp, sBus.bresp}), 64'd0);
      checkOutput("rstStates", 64'({dut.rdState_q, dut.wrState_q}), 64'({R_IDLE, W_IDLE}));
      @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      checkOutput("idleArready", 64'(sBus.arready), 64'd0);

      $display("[TB] EXT read, len=3");
      clearMonitors();
      applyStimulusRead(32'h8000_0000, 8'd3, 4'h9, 1'b0, 50);
      verifyBeats("ext4", 4, RESP_OKAY, 4'h9, 1);
      checkOutput("ext4NoClint", 64'(cArvSeen), 64'd0);
      checkOutput("ext4ExtAr", 64'(eArvSeen), 64'd1);

      $display("[TB] CLINT read, len=0");
      clearMonitors();
      applyStimulusRead(32'h0200_BFF8, 8'd0, 4'h1, 1'b0, 50);
      @(negedge clock);
      checkOutput("cltIdleAfter", 64'(dut.rdState_q), 64'(R_IDLE));
      checkOutput("cltArvalid", 64'(cArvSeen), 64'd1);
      checkOutput("cltAraddr", 64'(cAraddrSeen), 64'h0200_BFF8);
      verifyBeats("clt", 1, RESP_OKAY, 4'h1, 2);
`ifdef YSYX_XBAR_SKIP_EN
      checkOutput("cltSkip", 64'(skipCount), 64'd1);
`endif

      $display("[TB] Unmapped read, len=2, rready toggling");
      clearMonitors();
      applyStimulusRead(32'h0000_1000, 8'd2, 4'h5, 1'b1, 50);
      verifyBeats("err3", 3, RESP_DECERR, 4'h5, 0);
`ifdef YSYX_XBAR_SKIP_EN
      checkOutput("err3Skip", 64'(skipCount), 64'd1);
`endif

      $display("[TB] CLINT write, 2 beats");
      clearMonitors();
      applyStimulusWrite(32'h0200_0000, 2, 4'h3, 50, wAcc, wResp, wBid);
      checkOutput("cltWrBeats", 64'(wAcc), 64'd2);
      checkOutput("cltWrResp", 64'(wResp), 64'(RESP_SLVERR));
      checkOutput("cltWrBid", 64'(wBid), 64'h3);
      checkOutput("cltWrNoExtAw", 64'(eAwvSeen), 64'd0);
`ifdef YSYX_XBAR_SKIP_EN
      checkOutput("cltWrSkip", 64'(skipCount), 64'd1);
`endif

      $display("[TB] Unmapped write, 1 beat");
      clearMonitors();
      applyStimulusWrite(32'h1000_0000, 1, 4'hC, 50, wAcc, wResp, wBid);
      checkOutput("errWrResp", 64'(wResp), 64'(RESP_DECERR));
      checkOutput("errWrBid", 64'(wBid), 64'hC);

      $display("[TB] Concurrent EXT read and write");
      clearMonitors();
      fork
         applyStimulusRead(32'h8000_0040, 8'd1, 4'h2, 1'b0, 50);
         applyStimulusWrite(32'h8000_0100, 1, 4'h7, 50, wAcc, wResp, wBid);
      join
      verifyBeats("ccRd", 2, RESP_OKAY, 4'h2, 1);
      checkOutput("ccWrBeats", 64'(wAcc), 64'd1);
      checkOutput("ccWrResp", 64'(wResp), 64'(RESP_OKAY));
      checkOutput("ccWrBid", 64'(wBid), 64'h7);
      checkOutput("ccExtAw", 64'(eAwvSeen), 64'd1);
`ifdef YSYX_XBAR_SKIP_EN
      checkOutput("ccSkip", 64'(skipCount), 64'd0);
`endif

      $display("[TB] Boundary decodes around EXT_BASE");
      clearMonitors();
      applyStimulusRead(32'h1FFF_FFFF, 8'd0, 4'h1, 1'b0, 50);
      verifyBeats("belowExt", 1, RESP_DECERR, 4'h1, 0);
      clearMonitors();
      applyStimulusRead(32'h2000_0000, 8'd0, 4'hA, 1'b0, 50);
      verifyBeats("atExt", 1, RESP_OKAY, 4'hA, 1);

      $display("[TB] Unmapped read, len=255");
      clearMonitors();
      applyStimulusRead(32'h0000_0000, 8'd255, 4'hF, 1'b0, 600);
      verifyBeats("err256", 256, RESP_DECERR, 4'hF, 0);

      $display("[TB] Reset during second beat of an error burst");
      clearMonitors();
      @(posedge clock);
      #1;
      sBus.araddr = 32'h0000_2000; sBus.arlen = 8'd3; sBus.arid = 4'h6;
      sBus.arsize = 3'd2; sBus.arburst = 2'b01; sBus.arvalid = 1'b1; sBus.rready = 1'b1;
      midBeats = 0; midCyc = 0; midArDone = 1'b0;
      while (midBeats < 1 && midCyc < 50) begin
         @(negedge clock);
         if (sBus.arvalid && sBus.arready) midArDone = 1'b1;
         if (sBus.rvalid && sBus.rready) midBeats++;
         @(posedge clock);
         #1;
         if (midArDone) sBus.arvalid = 1'b0;
         midCyc++;
      end
      checkOutput("midFirstBeat", 64'(midBeats), 64'd1);
      reset = 1'b1;
      @(negedge clock);
      checkOutput("midRstHandshakes", allHandshakes(), 64'd0);
      sBus.arvalid = 1'b0;
      sBus.rready  = 1'b0;
      @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      checkOutput("midRstStates", 64'({dut.rdState_q, dut.wrState_q}), 64'({R_IDLE, W_IDLE}));
      checkOutput("midRstQuiet", allHandshakes(), 64'd0);
      clearMonitors();
      applyStimulusRead(32'h8000_0000, 8'd0, 4'h4, 1'b0, 50);
      verifyBeats("postRst", 1, RESP_OKAY, 4'h4, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
